// File: rtl/axi_txn_drain_ctrl.sv
// Transaction gate between an AXI4+ATOP port and a shared downstream resource.
// Optional stall statistics are enabled with `define AXI_TXN_DRAIN_STATS_EN.

package axi_txn_drain_pkg;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [5:0]  atop;
   } aw_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } ar_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      r_chan_t r;
      logic    r_valid;
   } axi_rsp_t;

endpackage

// State table
//   state       | meaning
//   ST_RUN      | traffic flows, AW/AR throttled at the outstanding limits
//   ST_DRAIN    | no new AW/AR, waiting for outstanding reads/writes/W bursts
//   ST_DRAINED  | fully idle, drain_ack_o high until drain_req_i drops
module axi_txn_drain_ctrl #(
   parameter int unsigned MaxReadTxns  = 8,
   parameter int unsigned MaxWriteTxns = 8,
   parameter type axi_req_t = axi_txn_drain_pkg::axi_req_t,
   parameter type axi_rsp_t = axi_txn_drain_pkg::axi_rsp_t,
   localparam int unsigned RdCntW = $clog2(MaxReadTxns + 1),
   localparam int unsigned WrCntW = $clog2(MaxWriteTxns + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              drain_req_i,
   output logic              drain_ack_o,
   output logic [RdCntW-1:0] rd_outstanding_o,
   output logic [WrCntW-1:0] wr_outstanding_o,
   output logic [31:0]       stall_cycles_o,
   input  axi_req_t          slv_req_i,
   output axi_rsp_t          slv_resp_o,
   output axi_req_t          mst_req_o,
   input  axi_rsp_t          mst_resp_i
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DRAINED
   } state_e;

   localparam logic [RdCntW-1:0] RdMax  = RdCntW'(MaxReadTxns);
   localparam logic [RdCntW:0]   RdMaxX = (RdCntW + 1)'(MaxReadTxns);
   localparam logic [RdCntW:0]   RdOneX = (RdCntW + 1)'(1);
   localparam logic [WrCntW-1:0] WrMax  = WrCntW'(MaxWriteTxns);
   localparam logic [WrCntW-1:0] WrOne  = WrCntW'(1);

   state_e            r_state;
   state_e            w_state_d;
   logic [RdCntW-1:0] r_rd_cnt;
   logic [WrCntW-1:0] r_wr_cnt;
   logic [WrCntW-1:0] r_w_owed;
   logic [RdCntW-1:0] w_rd_cnt_d;
   logic [WrCntW-1:0] w_wr_cnt_d;
   logic [WrCntW-1:0] w_w_owed_d;

   logic              w_run;
   logic              w_ar_allow;
   logic              w_ar_take;
   logic              w_aw_allow;
   logic              w_w_allow;
   logic              w_atop_rd;
   logic [RdCntW:0]   w_rd_after_ar;

   logic              w_ar_hs;
   logic              w_aw_hs;
   logic              w_w_last_hs;
   logic              w_b_hs;
   logic              w_rd_dec;
   logic [1:0]        w_rd_inc;
   logic [RdCntW:0]   w_rd_sum;

   assign w_run      = (r_state == ST_RUN);
   assign w_atop_rd  = slv_req_i.aw.atop[5];
   assign w_ar_allow = w_run && (r_rd_cnt < RdMax);
   assign w_ar_take  = slv_req_i.ar_valid && w_ar_allow;

   // An R_RESP atomic must leave read room even if an AR is accepted in the same cycle.
   assign w_rd_after_ar = {1'b0, r_rd_cnt} + (RdCntW + 1)'(w_ar_take);
   assign w_aw_allow    = w_run && (r_wr_cnt < WrMax) && (r_w_owed < WrMax)
                          && (!w_atop_rd || (w_rd_after_ar < RdMaxX));

   // W may lead AW while running; once draining only bursts already owed may pass.
   assign w_w_allow = w_run || (r_w_owed != '0);

   always_comb begin
      mst_req_o          = slv_req_i;
      mst_req_o.aw_valid = slv_req_i.aw_valid && w_aw_allow;
      mst_req_o.ar_valid = slv_req_i.ar_valid && w_ar_allow;
      mst_req_o.w_valid  = slv_req_i.w_valid  && w_w_allow;

      slv_resp_o          = mst_resp_i;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready && w_aw_allow;
      slv_resp_o.ar_ready = mst_resp_i.ar_ready && w_ar_allow;
      slv_resp_o.w_ready  = mst_resp_i.w_ready  && w_w_allow;
   end

   assign w_ar_hs     = slv_req_i.ar_valid && w_ar_allow && mst_resp_i.ar_ready;
   assign w_aw_hs     = slv_req_i.aw_valid && w_aw_allow && mst_resp_i.aw_ready;
   assign w_w_last_hs = slv_req_i.w_valid  && w_w_allow  && mst_resp_i.w_ready
                        && slv_req_i.w.last;
   assign w_b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
   assign w_rd_dec    = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
   assign w_rd_inc    = {1'b0, w_ar_hs} + {1'b0, w_aw_hs && w_atop_rd};

   always_comb begin
      w_rd_sum = {1'b0, r_rd_cnt} + (RdCntW + 1)'(w_rd_inc);
      if (w_rd_dec && (w_rd_sum != '0)) begin
         w_rd_sum = w_rd_sum - RdOneX;
      end
      w_rd_cnt_d = w_rd_sum[RdCntW-1:0];
   end

   always_comb begin
      w_wr_cnt_d = r_wr_cnt;
      if (w_aw_hs && !w_b_hs) begin
         w_wr_cnt_d = r_wr_cnt + WrOne;
      end else if (!w_aw_hs && w_b_hs && (r_wr_cnt != '0)) begin
         w_wr_cnt_d = r_wr_cnt - WrOne;
      end
   end

   always_comb begin
      w_w_owed_d = r_w_owed;
      if (w_aw_hs && !w_w_last_hs) begin
         w_w_owed_d = r_w_owed + WrOne;
      end else if (!w_aw_hs && w_w_last_hs && (r_w_owed != '0)) begin
         w_w_owed_d = r_w_owed - WrOne;
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         ST_RUN: begin
            if (drain_req_i) w_state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!drain_req_i) begin
               w_state_d = ST_RUN;
            end else if ((w_rd_cnt_d == '0) && (w_wr_cnt_d == '0) && (w_w_owed_d == '0)) begin
               w_state_d = ST_DRAINED;
            end
         end
         ST_DRAINED: begin
            if (!drain_req_i) w_state_d = ST_RUN;
         end
         default: w_state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_RUN;
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
         r_w_owed <= '0;
      end else begin
         r_state  <= w_state_d;
         r_rd_cnt <= w_rd_cnt_d;
         r_wr_cnt <= w_wr_cnt_d;
         r_w_owed <= w_w_owed_d;
      end
   end

   assign drain_ack_o      = (r_state == ST_DRAINED);
   assign rd_outstanding_o = r_rd_cnt;
   assign wr_outstanding_o = r_wr_cnt;

`ifdef AXI_TXN_DRAIN_STATS_EN
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = (slv_req_i.aw_valid && !w_aw_allow) || (slv_req_i.ar_valid && !w_ar_allow);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cycles_o = r_stall_cnt;
`else
   assign stall_cycles_o = '0;
`endif

`ifndef SYNTHESIS
   // A response with nothing outstanding is a protocol error; the counter holds at zero.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         a_rd_underflow: assert (!(w_rd_dec && (r_rd_cnt == '0) && (w_rd_inc == '0)));
         a_wr_underflow: assert (!(w_b_hs && (r_wr_cnt == '0) && !w_aw_hs));
      end
   end
`endif

endmodule

// File: tb/tb_axi_txn_drain_ctrl.sv
// Directed bench for axi_txn_drain_ctrl with limits of 2 reads / 2 writes.
// Stall expectation follows AXI_TXN_DRAIN_STATS_EN.
module tb_axi_txn_drain_ctrl;
   import axi_txn_drain_pkg::*;

`ifdef AXI_TXN_DRAIN_STATS_EN
   localparam logic [31:0] ExpStall = 32'd5;
`else
   localparam logic [31:0] ExpStall = 32'd0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        drain_req_i = 1'b0;
   logic        drain_ack_o;
   logic [1:0]  rd_outstanding_o;
   logic [1:0]  wr_outstanding_o;
   logic [31:0] stall_cycles_o;
   axi_req_t    slv_req;
   axi_req_t    mst_req;
   axi_rsp_t    slv_resp;
   axi_rsp_t    mst_resp;

   int n_checks = 0;
   int n_errors = 0;

   axi_txn_drain_ctrl #(
      .MaxReadTxns  (2),
      .MaxWriteTxns (2),
      .axi_req_t    (axi_req_t),
      .axi_rsp_t    (axi_rsp_t)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .drain_req_i      (drain_req_i),
      .drain_ack_o      (drain_ack_o),
      .rd_outstanding_o (rd_outstanding_o),
      .wr_outstanding_o (wr_outstanding_o),
      .stall_cycles_o   (stall_cycles_o),
      .slv_req_i        (slv_req),
      .slv_resp_o       (slv_resp),
      .mst_req_o        (mst_req),
      .mst_resp_i       (mst_resp)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      slv_req           = '0;
      slv_req.b_ready   = 1'b1;
      slv_req.r_ready   = 1'b1;
      mst_resp          = '0;
      mst_resp.aw_ready = 1'b1;
      mst_resp.ar_ready = 1'b1;
      mst_resp.w_ready  = 1'b1;
      mst_resp.r.last   = 1'b1;

      rst_i = 1'b1;
      repeat (3) tick();
      rst_i = 1'b0;
      settle();
      check("rst_rd", rd_outstanding_o, 0);
      check("rst_wr", wr_outstanding_o, 0);
      check("rst_ack", drain_ack_o, 0);
      check("rst_stall", stall_cycles_o, 0);

      slv_req.ar.addr = 32'h1234_5678;
      mst_resp.r.data = 32'hCAFE_0001;
      settle();
      check("pass_ar_addr", mst_req.ar.addr, 32'h1234_5678);
      check("pass_r_data", slv_resp.r.data, 32'hCAFE_0001);

      // three back-to-back ARs against a limit of two
      slv_req.ar_valid = 1'b1;
      settle();
      check("ar1_ready", slv_resp.ar_ready, 1);
      tick();
      check("ar1_cnt", rd_outstanding_o, 1);
      tick();
      check("ar2_cnt", rd_outstanding_o, 2);
      check("ar3_held_ready", slv_resp.ar_ready, 0);
      check("ar3_held_valid", mst_req.ar_valid, 0);
      repeat (5) tick();
      check("stall_5", stall_cycles_o, ExpStall);
      mst_resp.r_valid = 1'b1;
      settle();
      check("ar_gate_at_max_with_dec", slv_resp.ar_ready, 0);
      tick();
      mst_resp.r_valid = 1'b0;
      settle();
      check("r_dec_cnt", rd_outstanding_o, 1);
      check("ar3_ready", slv_resp.ar_ready, 1);
      tick();
      slv_req.ar_valid = 1'b0;
      settle();
      check("ar3_cnt", rd_outstanding_o, 2);
      mst_resp.r_valid = 1'b1;
      repeat (2) tick();
      mst_resp.r_valid = 1'b0;
      settle();
      check("rd_empty", rd_outstanding_o, 0);

      // AR and R-last in the same cycle at rd_cnt=1
      slv_req.ar_valid = 1'b1;
      tick();
      mst_resp.r_valid = 1'b1;
      tick();
      slv_req.ar_valid = 1'b0;
      settle();
      check("ar_r_same_cycle", rd_outstanding_o, 1);
      tick();
      mst_resp.r_valid = 1'b0;
      settle();
      check("rd_empty2", rd_outstanding_o, 0);

      // atomic with R response
      slv_req.aw_valid = 1'b1;
      slv_req.aw.atop  = 6'b100000;
      settle();
      check("atop_aw_ready", slv_resp.aw_ready, 1);
      tick();
      slv_req.aw_valid = 1'b0;
      slv_req.aw.atop  = 6'b000000;
      settle();
      check("atop_rd", rd_outstanding_o, 1);
      check("atop_wr", wr_outstanding_o, 1);
      slv_req.w_valid = 1'b1;
      slv_req.w.last  = 1'b1;
      tick();
      slv_req.w_valid  = 1'b0;
      mst_resp.r_valid = 1'b1;
      mst_resp.b_valid = 1'b1;
      tick();
      mst_resp.r_valid = 1'b0;
      mst_resp.b_valid = 1'b0;
      settle();
      check("atop_rd_done", rd_outstanding_o, 0);
      check("atop_wr_done", wr_outstanding_o, 0);

      // drain with one write outstanding
      slv_req.aw_valid = 1'b1;
      tick();
      slv_req.aw_valid = 1'b0;
      slv_req.w_valid  = 1'b1;
      tick();
      slv_req.w_valid = 1'b0;
      settle();
      check("drain_wr_pending", wr_outstanding_o, 1);
      drain_req_i = 1'b1;
      tick();
      slv_req.aw_valid = 1'b1;
      slv_req.ar_valid = 1'b1;
      settle();
      check("drain_aw_ready", slv_resp.aw_ready, 0);
      check("drain_ar_ready", slv_resp.ar_ready, 0);
      check("drain_aw_valid", mst_req.aw_valid, 0);
      check("drain_ack_pending", drain_ack_o, 0);
      tick();
      check("drain_ack_still_pending", drain_ack_o, 0);
      slv_req.aw_valid = 1'b0;
      slv_req.ar_valid = 1'b0;
      mst_resp.b_valid = 1'b1;
      tick();
      mst_resp.b_valid = 1'b0;
      settle();
      check("drain_wr_zero", wr_outstanding_o, 0);
      check("drain_ack", drain_ack_o, 1);
      slv_req.w_valid = 1'b1;
      settle();
      check("drained_w_ready", slv_resp.w_ready, 0);
      check("drained_w_valid", mst_req.w_valid, 0);
      slv_req.w_valid = 1'b0;
      drain_req_i = 1'b0;
      tick();
      check("release_ack", drain_ack_o, 0);

      // four-beat W burst owed while draining
      slv_req.aw_valid = 1'b1;
      slv_req.aw.len   = 8'd3;
      tick();
      slv_req.aw_valid = 1'b0;
      drain_req_i      = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         slv_req.w_valid = 1'b1;
         slv_req.w.last  = (i == 3);
         settle();
         check("burst_w_ready", slv_resp.w_ready, 1);
         tick();
      end
      slv_req.w.last = 1'b0;
      settle();
      check("burst_owed_zero", slv_resp.w_ready, 0);
      check("burst_ack_pending", drain_ack_o, 0);
      slv_req.w_valid  = 1'b0;
      mst_resp.b_valid = 1'b1;
      tick();
      mst_resp.b_valid = 1'b0;
      settle();
      check("burst_wr_zero", wr_outstanding_o, 0);
      check("burst_ack", drain_ack_o, 1);
      drain_req_i = 1'b0;
      tick();

      // minimum request-to-ack latency on an idle port
      drain_req_i = 1'b1;
      tick();
      check("lat_ack_1", drain_ack_o, 0);
      tick();
      check("lat_ack_2", drain_ack_o, 1);
      drain_req_i = 1'b0;
      tick();

      // reset in the middle of traffic
      slv_req.ar_valid = 1'b1;
      slv_req.aw_valid = 1'b1;
      tick();
      slv_req.ar_valid = 1'b0;
      slv_req.aw_valid = 1'b0;
      slv_req.w_valid  = 1'b1;
      slv_req.w.last   = 1'b0;
      settle();
      check("pre_rst_rd", rd_outstanding_o, 1);
      check("pre_rst_wr", wr_outstanding_o, 1);
      tick();
      rst_i = 1'b1;
      tick();
      rst_i           = 1'b0;
      slv_req.w_valid = 1'b0;
      settle();
      check("mid_rst_rd", rd_outstanding_o, 0);
      check("mid_rst_wr", wr_outstanding_o, 0);
      check("mid_rst_ack", drain_ack_o, 0);
      check("mid_rst_stall", stall_cycles_o, 0);
      slv_req.ar_valid = 1'b1;
      settle();
      check("mid_rst_run", slv_resp.ar_ready, 1);
      slv_req.ar_valid = 1'b0;
      settle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
